// File: rtl/sr_cond_pkg.sv
// Shared types and default constants for the SR command conditioner.
package sr_cond_pkg;

    typedef enum logic {
        PRIO_SET   = 1'b0,
        PRIO_RESET = 1'b1
    } sr_prio_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE    = 4;

    // Maps the integer RESET_PRIORITY parameter onto the priority enum.
    function automatic sr_prio_e prio_from_param(input int p);
        return (p != 0) ? PRIO_RESET : PRIO_SET;
    endfunction

endpackage

// File: rtl/sr_debounce_chan.sv
// One request channel: synchroniser, debounce counter and rising-edge flag.
module sr_debounce_chan
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   stable;
    logic                   rise_q;
    logic                   synced;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign level_out = stable;
    assign rise_out  = rise_q;

    // Shift the raw request through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles; flag 0->1 updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= synced;
                cnt    <= '0;
                rise_q <= synced;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/reset requests into S/R commands that never assert together.
module sr_cmd_conditioner
    import sr_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter int RESET_PRIORITY  = 1,
    parameter int PULSE_MODE      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    input  logic enable,
    output logic S,
    output logic R,
    output logic conflict,
    output logic set_db,
    output logic rst_db
);

    localparam sr_prio_e PRIO = prio_from_param(RESET_PRIORITY);
    localparam logic RST_WINS = (PRIO == PRIO_RESET);

    logic set_level, set_rise;
    logic rst_level, rst_rise;
    logic s_next, r_next, c_next;

    sr_debounce_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (set_req),
        .level_out(set_level),
        .rise_out (set_rise)
    );

    sr_debounce_chan #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_rst_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_in   (rst_req),
        .level_out(rst_level),
        .rise_out (rst_rise)
    );

    assign set_db = set_level;
    assign rst_db = rst_level;

    // Arbitrate edge events (pulse mode) or debounced levels (level mode) into S/R/conflict.
    always_comb begin
        s_next = 1'b0;
        r_next = 1'b0;
        c_next = 1'b0;
        if (PULSE_MODE != 0) begin
            if (set_rise && rst_rise) begin
                c_next = 1'b1;
                if (RST_WINS) begin
                    r_next = enable;
                end else begin
                    s_next = enable;
                end
            end else if (set_rise) begin
                s_next = enable;
            end else if (rst_rise) begin
                r_next = enable;
            end
        end else begin
            s_next = enable & set_level & ~(rst_level & RST_WINS);
            r_next = enable & rst_level & ~(set_level & ~RST_WINS);
            c_next = set_level & rst_level;
        end
    end

    // Register the commands so the flip-flop sees clean, glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S        <= s_next;
            R        <= r_next;
            conflict <= c_next;
        end
    end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Scoreboard bench: three conditioner instances (defaults, set-priority, level mode).
module tb_sr_cmd_conditioner;

    typedef struct {
        int   cyc;
        logic s;
        logic r;
        logic c;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic set_req [3];
    logic rst_req [3];
    logic enable  [3];
    logic s_o     [3];
    logic r_o     [3];
    logic c_o     [3];
    logic sdb_o   [3];
    logic rdb_o   [3];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q [3][$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sr_cmd_conditioner dut_def (
        .clk(clk), .rst_n(rst_n), .set_req(set_req[0]), .rst_req(rst_req[0]),
        .enable(enable[0]), .S(s_o[0]), .R(r_o[0]), .conflict(c_o[0]),
        .set_db(sdb_o[0]), .rst_db(rdb_o[0])
    );

    sr_cmd_conditioner #(.RESET_PRIORITY(0)) dut_sprio (
        .clk(clk), .rst_n(rst_n), .set_req(set_req[1]), .rst_req(rst_req[1]),
        .enable(enable[1]), .S(s_o[1]), .R(r_o[1]), .conflict(c_o[1]),
        .set_db(sdb_o[1]), .rst_db(rdb_o[1])
    );

    sr_cmd_conditioner #(.PULSE_MODE(0)) dut_level (
        .clk(clk), .rst_n(rst_n), .set_req(set_req[2]), .rst_req(rst_req[2]),
        .enable(enable[2]), .S(s_o[2]), .R(r_o[2]), .conflict(c_o[2]),
        .set_db(sdb_o[2]), .rst_db(rdb_o[2])
    );

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0b, expected %0b (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input int id, input logic s, input logic r, input logic en);
        set_req[id] = s;
        rst_req[id] = r;
        enable[id]  = en;
    endtask

    task automatic push_exp(input int id, input int from_cyc, input int to_cyc,
                            input logic s, input logic r, input logic c);
        for (int k = from_cyc; k <= to_cyc; k++) begin
            exp_q[id].push_back('{cyc: k, s: s, r: r, c: c});
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: pop an expectation whenever any command output is active.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL missed_output inst%0d: got nothing at cycle %0d, expected S/R/C=%0b%0b%0b",
                             i, exp_q[i][0].cyc, exp_q[i][0].s, exp_q[i][0].r, exp_q[i][0].c);
                    void'(exp_q[i].pop_front());
                end
                n_checks++;
                if ((s_o[i] & r_o[i]) !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL sr_exclusive inst%0d: got S=%0b R=%0b, expected not both 1",
                             i, s_o[i], r_o[i]);
                end
                if (s_o[i] | r_o[i] | c_o[i]) begin
                    n_checks++;
                    if (exp_q[i].size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL unexpected_output inst%0d: got S/R/C=%0b%0b%0b at cycle %0d, expected none",
                                 i, s_o[i], r_o[i], c_o[i], cyc);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        if (mon_e.cyc != cyc || mon_e.s !== s_o[i] || mon_e.r !== r_o[i] || mon_e.c !== c_o[i]) begin
                            n_fail++;
                            $display("[TB] FAIL output inst%0d: got S/R/C=%0b%0b%0b at cycle %0d, expected %0b%0b%0b at cycle %0d",
                                     i, s_o[i], r_o[i], c_o[i], cyc, mon_e.s, mon_e.r, mon_e.c, mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n, m, k, rel;
        for (int i = 0; i < 3; i++) apply_stimulus(i, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("reset_S_%0d", i), s_o[i], 1'b0);
            check_output($sformatf("reset_R_%0d", i), r_o[i], 1'b0);
            check_output($sformatf("reset_conflict_%0d", i), c_o[i], 1'b0);
            check_output($sformatf("reset_set_db_%0d", i), sdb_o[i], 1'b0);
            check_output($sformatf("reset_rst_db_%0d", i), rdb_o[i], 1'b0);
        end
        rst_n = 1'b1;
        wait_until(cyc + 3);

        // Clean set edge: one S pulse seven edges after the sampling edge.
        n = cyc;
        apply_stimulus(0, 1'b1, 1'b0, 1'b1);
        push_exp(0, n + 7, n + 7, 1'b1, 1'b0, 1'b0);
        wait_until(n + 5);
        check_output("set_db_before_accept", sdb_o[0], 1'b0);
        wait_until(n + 6);
        check_output("set_db_at_accept", sdb_o[0], 1'b1);
        wait_until(n + 12);
        check_output("set_db_held", sdb_o[0], 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        wait_until(cyc + 10);

        // Glitch of three synced cycles is rejected.
        n = cyc;
        apply_stimulus(0, 1'b1, 1'b0, 1'b1);
        wait_until(n + 3);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        wait_until(n + 12);
        check_output("glitch3_set_db", sdb_o[0], 1'b0);

        // Four synced cycles is just enough to be accepted.
        n = cyc;
        apply_stimulus(0, 1'b1, 1'b0, 1'b1);
        wait_until(n + 4);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        push_exp(0, n + 7, n + 7, 1'b1, 1'b0, 1'b0);
        wait_until(n + 7);
        check_output("pulse4_set_db", sdb_o[0], 1'b1);
        wait_until(n + 16);
        check_output("pulse4_set_db_fall", sdb_o[0], 1'b0);

        // Simultaneous edges: reset wins on inst0, set wins on inst1.
        n = cyc;
        apply_stimulus(0, 1'b1, 1'b1, 1'b1);
        apply_stimulus(1, 1'b1, 1'b1, 1'b1);
        push_exp(0, n + 7, n + 7, 1'b0, 1'b1, 1'b1);
        push_exp(1, n + 7, n + 7, 1'b1, 1'b0, 1'b1);
        wait_until(n + 10);
        check_output("both_rst_db", rdb_o[0], 1'b1);
        check_output("both_set_db_sprio", sdb_o[1], 1'b1);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1, 1'b1, 1'b0, 1'b1);
        wait_until(cyc + 10);

        // enable low at the output edge discards the event; no late pulse.
        n = cyc;
        apply_stimulus(0, 1'b0, 1'b1, 1'b0);
        wait_until(n + 7);
        check_output("disabled_rst_db", rdb_o[0], 1'b1);
        check_output("disabled_R", r_o[0], 1'b0);
        wait_until(n + 8);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        wait_until(cyc + 12);

        // enable low only during debouncing still lets the pulse through.
        n = cyc;
        apply_stimulus(0, 1'b1, 1'b0, 1'b0);
        wait_until(n + 3);
        apply_stimulus(0, 1'b1, 1'b0, 1'b1);
        push_exp(0, n + 7, n + 7, 1'b1, 1'b0, 1'b0);
        wait_until(n + 10);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        wait_until(cyc + 10);

        // Level mode: S follows set_db until reset overlaps, then R and conflict every cycle.
        n = cyc;
        m = n + 10;
        k = m + 10;
        apply_stimulus(2, 1'b1, 1'b0, 1'b1);
        push_exp(2, n + 7, m + 6, 1'b1, 1'b0, 1'b0);
        wait_until(m);
        apply_stimulus(2, 1'b1, 1'b1, 1'b1);
        push_exp(2, m + 7, k + 6, 1'b0, 1'b1, 1'b1);
        wait_until(k);
        check_output("level_rst_db", rdb_o[2], 1'b1);
        apply_stimulus(2, 1'b0, 1'b0, 1'b1);
        wait_until(k + 12);

        // Reset mid-debounce clears state at once; held inputs re-fire after release.
        check_output("pre_reset_set_db_sprio", sdb_o[1], 1'b1);
        n = cyc;
        apply_stimulus(0, 1'b1, 1'b0, 1'b1);
        wait_until(n + 4);
        rst_n = 1'b0;
        #1;
        check_output("async_reset_set_db_sprio", sdb_o[1], 1'b0);
        check_output("async_reset_S", s_o[0], 1'b0);
        check_output("async_reset_set_db", sdb_o[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        push_exp(0, rel + 7, rel + 7, 1'b1, 1'b0, 1'b0);
        push_exp(1, rel + 7, rel + 7, 1'b1, 1'b0, 1'b0);
        wait_until(rel + 5);
        check_output("post_reset_set_db_early", sdb_o[0], 1'b0);
        wait_until(rel + 6);
        check_output("post_reset_set_db", sdb_o[0], 1'b1);
        wait_until(rel + 12);
        apply_stimulus(0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1, 1'b0, 1'b0, 1'b1);
        wait_until(cyc + 12);

        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (exp_q[i].size() != 0) begin
                n_fail++;
                $display("[TB] FAIL drained_inst%0d: got %0d pending, expected 0", i, exp_q[i].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
Upstream stage of the sr_flip_flop. It takes two asynchronous, possibly bouncing request lines (set and reset) and synchronises and debounces each one. It then arbitrates them and drives the flip-flop's S and R inputs. S=R=1, the forbidden SR combination, never leaves this block.

Parameters:
SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4)
DEBOUNCE_CYCLES, 4, consecutive stable synced cycles required to accept a level change (legal ≥1)
RESET_PRIORITY, 1, when both channels produce events together: 1 = R wins, 0 = S wins
PULSE_MODE, 1, 1 = one-cycle S/R pulse on each accepted rising edge; 0 = S/R follow the debounced levels
CNT_W, $clog2(DEBOUNCE_CYCLES+1), localparam, debounce counter width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
set_req  in  1  raw asynchronous set request
rst_req  in  1  raw asynchronous reset request
enable  in  1  synchronous; 0 suppresses S/R output; debouncing continues
S  out  1  registered set command to sr_flip_flop
R  out  1  registered reset command to sr_flip_flop
conflict  out  1  registered one-cycle flag: both events in the same cycle
set_db  out  1  debounced set level (observability)
rst_db  out  1  debounced reset level (observability)

Behaviour:
- Reset (rst_n=0, asynchronous): all sync flops, counters, stable levels, S, R, conflict, set_db and rst_db are 0 immediately. They stay 0 while rst_n=0.
- Synchroniser: SYNC_STAGES-flop shift per channel. The last stage is "synced".
- Debounce, per channel:
  - If synced == stable, cnt <= 0.
  - Otherwise cnt increments each cycle.
  - When cnt == DEBOUNCE_CYCLES-1 and the levels still differ: stable <= synced and cnt <= 0.
  - Any return to the stable value before that point clears cnt, so a glitch shorter than DEBOUNCE_CYCLES synced cycles is ignored.
- Event: rise = stable is updating 0→1 on this edge. Falling edges produce no event in PULSE_MODE=1.
- Arbitration, PULSE_MODE=1:
  - set_rise only: S <= enable.
  - rst_rise only: R <= enable.
  - Both on the same cycle: only the priority winner is asserted (gated by enable), and conflict <= 1.
  - Otherwise S, R and conflict are 0.
- Arbitration, PULSE_MODE=0:
  - S <= enable & set_db & ~(rst_db & RESET_PRIORITY).
  - R <= enable & rst_db & ~(set_db & ~RESET_PRIORITY).
  - conflict <= set_db & rst_db, asserted every cycle the overlap holds.
- Invariant: S & R == 0 in every cycle, in every mode.
- Latency: a raw rising edge that is stable from the clock edge that samples it produces S/R high after SYNC_STAGES + DEBOUNCE_CYCLES + 1 clock edges. With defaults this is 7.
- S, R and conflict are each exactly one cycle wide in PULSE_MODE=1.
- enable is sampled on the output edge only. An event whose output edge has enable=0 is discarded, not queued.
- Reset mid-operation clears any in-progress debounce count. After rst_n releases with a raw input already held high, that input is treated as a new rising edge and produces a pulse after the full latency.

Decomposition:
- Package sr_cond_pkg: typedef enum logic {PRIO_SET, PRIO_RESET} sr_prio_e, plus default constants DEF_SYNC_STAGES=2 and DEF_DEBOUNCE=4.
- Sub-module sr_debounce_chan (parameters SYNC_STAGES and DEBOUNCE_CYCLES; ports clk, rst_n, raw_in, level_out, rise_out). It contains the synchroniser, debounce counter and edge detection, and is instantiated twice.
- The top level holds arbitration and the output registers only.

Test Plan:
- Defaults; set_req 0→1 and held → S=1 for exactly one cycle, 7 edges after the sampling edge; R=0, conflict=0, set_db stays 1.
- set_req high for only 3 synced cycles, then low → no S pulse, set_db stays 0.
- set_req and rst_req rise on the same cycle, RESET_PRIORITY=1 → R=1, S=0 and conflict=1 for one cycle. Repeat with RESET_PRIORITY=0 → S=1, R=0, conflict=1.
- enable=0 during a valid rst_req edge → R stays 0 and rst_db becomes 1. Raising enable afterwards produces no late pulse.
- PULSE_MODE=0, set_req held and rst_req then asserted → S=1 until rst_db=1, then R=1, S=0 and conflict=1 every cycle of the overlap.
- rst_n pulsed low midway through a debounce count → all outputs 0 immediately. After release with set_req still high → S pulse 7 edges after release.
